// File: rtl/io_terminal.sv
// Peripheral-side I/O terminal: a host-to-CPU FIFO feeding INPR/FGI and a CPU-to-host
// FIFO fed by OUTR/FGO, with sticky underrun/overrun error flags.
module io_terminal #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] INPR_Register,
  output logic                  FGI,
  input  logic                  inp_ack,
  input  logic [DATA_WIDTH-1:0] OUTR_Register,
  input  logic                  out_strobe,
  output logic                  FGO,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  inp_underrun,
  output logic                  out_overrun,
  input  logic                  err_clear
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] imem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] imem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] omem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] omem_d [FIFO_DEPTH];
  logic [PW-1:0] iwr_q, iwr_d, ird_q, ird_d;
  logic [PW-1:0] owr_q, owr_d, ord_q, ord_d;
  logic [CW-1:0] icnt_q, icnt_d, ocnt_q, ocnt_d;
  logic          inp_underrun_q, inp_underrun_d;
  logic          out_overrun_q, out_overrun_d;
  logic          push_i, pop_i, push_o, pop_o;

  // Every output is a function of registered state only.
  assign in_ready      = (icnt_q != FULL);
  assign FGI           = (icnt_q != '0);
  assign INPR_Register = FGI ? imem_q[ird_q] : '0;
  assign FGO           = (ocnt_q != FULL);
  assign out_valid     = (ocnt_q != '0);
  assign out_data      = out_valid ? omem_q[ord_q] : '0;
  assign inp_underrun  = inp_underrun_q;
  assign out_overrun   = out_overrun_q;

  assign push_i = in_valid && in_ready;
  assign pop_i  = inp_ack && FGI;
  assign push_o = out_strobe && FGO;
  assign pop_o  = out_valid && out_ready;

  always_comb begin
    imem_d = imem_q;
    iwr_d  = iwr_q;
    ird_d  = ird_q;
    icnt_d = icnt_q;
    if (push_i) begin
      imem_d[iwr_q] = in_data;
      iwr_d         = iwr_q + 1'b1;
    end
    if (pop_i) ird_d = ird_q + 1'b1;
    if (push_i && !pop_i) icnt_d = icnt_q + CW'(1);
    else if (!push_i && pop_i) icnt_d = icnt_q - CW'(1);
  end

  always_comb begin
    omem_d = omem_q;
    owr_d  = owr_q;
    ord_d  = ord_q;
    ocnt_d = ocnt_q;
    if (push_o) begin
      omem_d[owr_q] = OUTR_Register;
      owr_d         = owr_q + 1'b1;
    end
    if (pop_o) ord_d = ord_q + 1'b1;
    if (push_o && !pop_o) ocnt_d = ocnt_q + CW'(1);
    else if (!push_o && pop_o) ocnt_d = ocnt_q - CW'(1);
  end

  // A new error event outranks err_clear in the same cycle.
  always_comb begin
    inp_underrun_d = inp_underrun_q;
    out_overrun_d  = out_overrun_q;
    if (err_clear) begin
      inp_underrun_d = 1'b0;
      out_overrun_d  = 1'b0;
    end
    if (inp_ack && !FGI)   inp_underrun_d = 1'b1;
    if (out_strobe && !FGO) out_overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iwr_q          <= '0;
      ird_q          <= '0;
      icnt_q         <= '0;
      owr_q          <= '0;
      ord_q          <= '0;
      ocnt_q         <= '0;
      inp_underrun_q <= 1'b0;
      out_overrun_q  <= 1'b0;
    end else begin
      iwr_q          <= iwr_d;
      ird_q          <= ird_d;
      icnt_q         <= icnt_d;
      owr_q          <= owr_d;
      ord_q          <= ord_d;
      ocnt_q         <= ocnt_d;
      inp_underrun_q <= inp_underrun_d;
      out_overrun_q  <= out_overrun_d;
    end
  end

  // Storage is not reset; zero counts hide stale entries from the outputs.
  always_ff @(posedge clk) begin
    imem_q <= imem_d;
    omem_q <= omem_d;
  end

endmodule

// File: tb/tb_io_terminal.sv
// Bench for io_terminal: directed vector table, hand sequences for full/reset corners,
// and randomized traffic against a queue-based reference model.
module tb_io_terminal;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data, INPR_Register, OUTR_Register, out_data;
  logic        in_valid, in_ready, FGI, inp_ack, out_strobe, FGO, out_valid, out_ready;
  logic        inp_underrun, out_overrun, err_clear;

  int checks = 0;
  int errors = 0;

  io_terminal #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .INPR_Register(INPR_Register), .FGI(FGI), .inp_ack(inp_ack),
    .OUTR_Register(OUTR_Register), .out_strobe(out_strobe), .FGO(FGO),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .inp_underrun(inp_underrun), .out_overrun(out_overrun), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;  logic [15:0] id;  logic ack;
    logic        os;  logic [15:0] outr; logic ordy; logic ec;
    logic        e_irdy; logic e_fgi; logic [15:0] e_inpr;
    logic        e_fgo;  logic e_ov;  logic [15:0] e_od;
    logic        e_und;  logic e_ovr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic irdy, input logic fgi, input logic [15:0] inpr,
                         input logic fgo, input logic ov, input logic [15:0] od,
                         input logic und, input logic ovr);
    chk({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, irdy});
    chk({tag, ".FGI"}, {15'd0, FGI}, {15'd0, fgi});
    chk({tag, ".INPR"}, INPR_Register, inpr);
    chk({tag, ".FGO"}, {15'd0, FGO}, {15'd0, fgo});
    chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, ov});
    chk({tag, ".out_data"}, out_data, od);
    chk({tag, ".underrun"}, {15'd0, inp_underrun}, {15'd0, und});
    chk({tag, ".overrun"}, {15'd0, out_overrun}, {15'd0, ovr});
  endtask

  task automatic idle();
    in_valid = 0; in_data = '0; inp_ack = 0; out_strobe = 0;
    OUTR_Register = '0; out_ready = 0; err_clear = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference model state
  logic [15:0] iq[$];
  logic [15:0] oq[$];
  logic        m_und, m_ovr;

  initial begin
    reset = 1; idle();
    step(); step();
    reset = 0;
    chk_all("reset", 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);

    // iv id ack os outr ordy ec | irdy fgi inpr fgo ov od und ovr
    vecs.push_back('{1,16'h0011,0,0,16'h0,0,0, 1,1,16'h0011,1,0,16'h0,0,0});
    vecs.push_back('{1,16'h0022,0,0,16'h0,0,0, 1,1,16'h0011,1,0,16'h0,0,0});
    vecs.push_back('{0,16'h0,1,0,16'h0,0,0,    1,1,16'h0022,1,0,16'h0,0,0});
    vecs.push_back('{0,16'h0,1,0,16'h0,0,0,    1,0,16'h0000,1,0,16'h0,0,0});
    vecs.push_back('{0,16'h0,1,0,16'h0,0,0,    1,0,16'h0000,1,0,16'h0,1,0});
    vecs.push_back('{0,16'h0,0,0,16'h0,0,1,    1,0,16'h0000,1,0,16'h0,0,0});
    vecs.push_back('{0,16'h0,0,1,16'hBEEF,0,0, 1,0,16'h0000,1,1,16'hBEEF,0,0});
    vecs.push_back('{0,16'h0,0,1,16'h1111,0,0, 1,0,16'h0000,1,1,16'hBEEF,0,0});
    vecs.push_back('{0,16'h0,0,1,16'h2222,0,0, 1,0,16'h0000,1,1,16'hBEEF,0,0});
    vecs.push_back('{0,16'h0,0,1,16'h3333,0,0, 1,0,16'h0000,0,1,16'hBEEF,0,0});
    vecs.push_back('{0,16'h0,0,1,16'h1234,0,0, 1,0,16'h0000,0,1,16'hBEEF,0,1});
    vecs.push_back('{0,16'h0,0,1,16'h5555,0,1, 1,0,16'h0000,0,1,16'hBEEF,0,1});
    vecs.push_back('{0,16'h0,0,0,16'h0,0,1,    1,0,16'h0000,0,1,16'hBEEF,0,0});
    vecs.push_back('{0,16'h0,0,0,16'h0,1,0,    1,0,16'h0000,1,1,16'h1111,0,0});
    vecs.push_back('{0,16'h0,0,0,16'h0,1,0,    1,0,16'h0000,1,1,16'h2222,0,0});
    vecs.push_back('{0,16'h0,0,0,16'h0,1,0,    1,0,16'h0000,1,1,16'h3333,0,0});
    vecs.push_back('{0,16'h0,0,0,16'h0,1,0,    1,0,16'h0000,1,0,16'h0000,0,0});

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; inp_ack = vecs[i].ack;
      out_strobe = vecs[i].os; OUTR_Register = vecs[i].outr;
      out_ready = vecs[i].ordy; err_clear = vecs[i].ec;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_fgi, vecs[i].e_inpr,
              vecs[i].e_fgo, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_und, vecs[i].e_ovr);
    end
    idle();

    // Input FIFO full, refused fifth word, push+pop at count 3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 16'hA000 + 16'(i);
      step();
    end
    chk("full.in_ready", {15'd0, in_ready}, 16'd0);
    in_data = 16'hA004; step();
    in_valid = 0;
    chk("full.hold_ready", {15'd0, in_ready}, 16'd0);
    chk("full.head", INPR_Register, 16'hA000);
    inp_ack = 1; step();
    chk("full.after_ack", INPR_Register, 16'hA001);
    chk("full.ready_again", {15'd0, in_ready}, 16'd1);
    in_valid = 1; in_data = 16'hA005; step();
    in_valid = 0;
    chk("full.pushpop_head", INPR_Register, 16'hA002);
    chk("full.pushpop_cnt3", {15'd0, in_ready}, 16'd1);
    step(); chk("full.drain0", INPR_Register, 16'hA003);
    step(); chk("full.drain1", INPR_Register, 16'hA005);
    step(); chk("full.drain_empty", {15'd0, FGI}, 16'd0);
    inp_ack = 0; idle(); step();

    // Reset mid-operation
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = 16'hC000 + 16'(i);
      out_strobe = 1; OUTR_Register = 16'hD000 + 16'(i);
      step();
    end
    idle();
    reset = 1; inp_ack = 1; out_strobe = 1; OUTR_Register = 16'hDEAD; out_ready = 1;
    step();
    chk_all("midreset", 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    reset = 0; idle(); step();
    chk_all("postreset", 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);

    // Randomized traffic vs model
    iq.delete(); oq.delete(); m_und = 0; m_ovr = 0;
    for (int c = 0; c < 400; c++) begin
      logic iv, ack, os, ordy, ec, rst;
      logic [15:0] id, outr;
      iv = 1'($urandom_range(0, 1)); id = 16'($urandom);
      ack = ($urandom_range(0, 2) == 0); os = 1'($urandom_range(0, 1));
      outr = 16'($urandom); ordy = ($urandom_range(0, 2) == 0);
      ec = ($urandom_range(0, 7) == 0); rst = ($urandom_range(0, 99) == 0);
      in_valid = iv; in_data = id; inp_ack = ack; out_strobe = os;
      OUTR_Register = outr; out_ready = ordy; err_clear = ec; reset = rst;
      if (rst) begin
        iq.delete(); oq.delete(); m_und = 0; m_ovr = 0;
      end else begin
        bit ipush, ipop, opush, opop;
        ipush = iv && (iq.size() < 4);
        ipop  = ack && (iq.size() > 0);
        opush = os && (oq.size() < 4);
        opop  = ordy && (oq.size() > 0);
        if (ec) begin m_und = 0; m_ovr = 0; end
        if (ack && iq.size() == 0) m_und = 1;
        if (os && oq.size() == 4) m_ovr = 1;
        if (ipop) void'(iq.pop_front());
        if (ipush) iq.push_back(id);
        if (opop) void'(oq.pop_front());
        if (opush) oq.push_back(outr);
      end
      step();
      chk_all($sformatf("rand%0d", c), iq.size() < 4, iq.size() > 0,
              (iq.size() > 0) ? iq[0] : 16'h0000, oq.size() < 4, oq.size() > 0,
              (oq.size() > 0) ? oq[0] : 16'h0000, m_und, m_ovr);
    end
    reset = 0; idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
